// File: rtl/i2s_tx_pkg.sv
// Shared encodings and helpers for the multi-format serial audio transmitter.
package i2s_tx_pkg;

    localparam logic [1:0] FORMAT_I2S = 2'd0;
    localparam logic [1:0] FORMAT_LJ  = 2'd1;
    localparam logic [1:0] FORMAT_RJ  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic IDLE_SCLK  = 1'b1;
    localparam logic IDLE_SDATA = 1'b0;
    localparam logic IDLE_LRCLK = 1'b0;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Frame counter plus registered SCLK/LRCLK generation and the shift/load strobes.
module i2s_tx_clkgen
    import i2s_tx_pkg::*;
#(
    parameter int SLOT_W        = 32,
    parameter int MCLK_PER_SCLK = 8
) (
    input  logic MCLK_i,
    input  logic nRST_i,
    input  logic i_run,
    input  logic i_left_high,
    output logic SCLK_o,
    output logic LRCLK_o,
    output logic o_fall_en,
    output logic o_load_en
);
    localparam int F  = 2 * SLOT_W * MCLK_PER_SCLK;
    localparam int CW = clog2(F);
    localparam int PW = clog2(MCLK_PER_SCLK);
    localparam int H  = MCLK_PER_SCLK / 2;

    logic [CW-1:0] r_cnt;
    logic          r_sclk;
    logic          r_lrclk;
    logic [PW-1:0] w_phase;
    logic          w_last;

    assign w_phase   = r_cnt[PW-1:0];
    assign w_last    = (r_cnt == CW'(F - 1));
    assign o_fall_en = i_run && (w_phase == '0);
    assign o_load_en = i_run && w_last;
    assign SCLK_o    = r_sclk;
    assign LRCLK_o   = r_lrclk;

    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            r_cnt   <= '0;
            r_sclk  <= IDLE_SCLK;
            r_lrclk <= IDLE_LRCLK;
        end else if (!i_run) begin
            r_cnt   <= '0;
            r_sclk  <= IDLE_SCLK;
            r_lrclk <= IDLE_LRCLK;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_phase == '0)
                r_sclk <= 1'b0;
            else if (w_phase == PW'(H))
                r_sclk <= 1'b1;
            // Word clock switches on the falling SCLK edge that opens each slot.
            if (r_cnt == '0)
                r_lrclk <= i_left_high;
            else if (r_cnt == CW'(SLOT_W * MCLK_PER_SCLK))
                r_lrclk <= !i_left_high;
        end
    end

endmodule

// File: rtl/i2s_multiformat_tx.sv
// Stereo parallel-to-serial audio transmitter (I2S / left- / right-justified) with a
// single-entry sample buffer that loads on frame boundaries.
module i2s_multiformat_tx
    import i2s_tx_pkg::*;
#(
    parameter int DATA_W        = 24,
    parameter int SLOT_W        = 32,
    parameter int MCLK_PER_SCLK = 8
) (
    input  logic              MCLK_i,
    input  logic              nRST_i,
    input  logic [DATA_W-1:0] PDATA_LEFT_i,
    input  logic [DATA_W-1:0] PDATA_RIGHT_i,
    input  logic              PDATA_VALID_i,
    input  logic              EN_i,
    input  logic              MUTE_i,
    input  logic [1:0]        FORMAT_i,
    output logic              SCLK_o,
    output logic              SDATA_o,
    output logic              LRCLK_o,
    output logic              FRAME_START_o,
    output logic              UNDERRUN_o,
    output logic              OVERRUN_o,
    output logic [1:0]        STATE_DBG_o
);
    localparam int FB = 2 * SLOT_W;

    // PDATA_VALID_i is a one-cycle strobe with no back-pressure: it always captures,
    // overwriting an unconsumed sample (overrun) unless a frame load consumes it that cycle.
    state_t            r_state;
    logic [DATA_W-1:0] r_buf_l;
    logic [DATA_W-1:0] r_buf_r;
    logic              r_buf_full;
    logic [FB-1:0]     r_shift;
    logic              r_dly;
    logic [1:0]        r_fmt;
    logic              r_sdata;
    logic              r_frame_start;
    logic              r_underrun;
    logic              r_overrun;

    logic              w_run;
    logic              w_fall_en;
    logic              w_load_en;
    logic              w_load;
    logic [1:0]        w_fmt_in;
    logic [SLOT_W-1:0] w_slot_l;
    logic [SLOT_W-1:0] w_slot_r;

    assign w_fmt_in = (FORMAT_i == FORMAT_I2S || FORMAT_i == FORMAT_RJ) ? FORMAT_i : FORMAT_LJ;
    assign w_run    = EN_i && (r_state == ST_RUN);
    assign w_load   = EN_i && ((r_state == ST_LOAD) || ((r_state == ST_RUN) && w_load_en));

    i2s_tx_clkgen #(
        .SLOT_W        (SLOT_W),
        .MCLK_PER_SCLK (MCLK_PER_SCLK)
    ) u_clkgen (
        .MCLK_i      (MCLK_i),
        .nRST_i      (nRST_i),
        .i_run       (w_run),
        .i_left_high (r_fmt != FORMAT_I2S),
        .SCLK_o      (SCLK_o),
        .LRCLK_o     (LRCLK_o),
        .o_fall_en   (w_fall_en),
        .o_load_en   (w_load_en)
    );

    // Slot images are built from the buffer as it stands; an underrun simply reuses it.
    always_comb begin
        w_slot_l = '0;
        w_slot_r = '0;
        if (!MUTE_i) begin
            if (w_fmt_in == FORMAT_RJ) begin
                w_slot_l = {SLOT_W{r_buf_l[DATA_W-1]}};
                w_slot_r = {SLOT_W{r_buf_r[DATA_W-1]}};
                w_slot_l[DATA_W-1:0] = r_buf_l;
                w_slot_r[DATA_W-1:0] = r_buf_r;
            end else begin
                w_slot_l[SLOT_W-1 -: DATA_W] = r_buf_l;
                w_slot_r[SLOT_W-1 -: DATA_W] = r_buf_r;
            end
        end
    end

    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            r_state       <= ST_IDLE;
            r_buf_l       <= '0;
            r_buf_r       <= '0;
            r_buf_full    <= 1'b0;
            r_shift       <= '0;
            r_dly         <= 1'b0;
            r_fmt         <= FORMAT_I2S;
            r_sdata       <= IDLE_SDATA;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_overrun     <= 1'b0;
            if (!EN_i) begin
                r_state    <= ST_IDLE;
                r_buf_full <= 1'b0;
                r_dly      <= 1'b0;
                r_sdata    <= IDLE_SDATA;
            end else begin
                if (PDATA_VALID_i) begin
                    r_buf_l    <= PDATA_LEFT_i;
                    r_buf_r    <= PDATA_RIGHT_i;
                    r_buf_full <= 1'b1;
                    if (r_buf_full && !w_load && r_state != ST_IDLE)
                        r_overrun <= 1'b1;
                end else if (w_load) begin
                    r_buf_full <= 1'b0;
                end

                case (r_state)
                    ST_IDLE: if (r_buf_full) r_state <= ST_LOAD;
                    ST_LOAD: r_state <= ST_RUN;
                    default: r_state <= ST_RUN;
                endcase

                if (w_load) begin
                    r_shift       <= {w_slot_l, w_slot_r};
                    r_fmt         <= w_fmt_in;
                    r_frame_start <= 1'b1;
                    r_underrun    <= !r_buf_full;
                end else if (w_fall_en) begin
                    // r_dly carries the previous bit so I2S lags LRCLK by one SCLK.
                    r_shift <= r_shift << 1;
                    r_dly   <= r_shift[FB-1];
                    r_sdata <= (r_fmt == FORMAT_I2S) ? r_dly : r_shift[FB-1];
                end
            end
        end
    end

    assign SDATA_o       = r_sdata;
    assign FRAME_START_o = r_frame_start;
    assign UNDERRUN_o    = r_underrun;
    assign OVERRUN_o     = r_overrun;
    assign STATE_DBG_o   = r_state;

endmodule

// File: doc/i2s_multiformat_tx.md
# i2s_multiformat_tx

Parametrised serial audio transmitter for the APU output path. It converts stereo parallel samples into I2S, left-justified or right-justified serial audio, with configurable sample width, slot width and MCLK/SCLK ratio. A single-entry sample buffer supports frame-boundary loading and reports underrun and overrun events. The block sits between the audio resampler/filter stage and the HDMI transmitter's I2S input.

## Interface
Parameters:
- DATA_W, 24, sample width in bits (8..32, ≤ SLOT_W)
- SLOT_W, 32, SCLK periods per channel slot (16 or 32)
- MCLK_PER_SCLK, 8, MCLK cycles per SCLK period (power of two, ≥ 2)

Ports:
- MCLK_i  in  1  master clock
- nRST_i  in  1  reset, asynchronous, active-low
- PDATA_LEFT_i  in  DATA_W  left sample, two's complement
- PDATA_RIGHT_i  in  DATA_W  right sample, two's complement
- PDATA_VALID_i  in  1  one-cycle strobe that captures both samples
- EN_i  in  1  transmitter enable
- MUTE_i  in  1  transmit zero samples
- FORMAT_i  in  2  0 = I2S, 1 = left-justified, 2 = right-justified, 3 = treated as left-justified
- SCLK_o  out  1  bit clock
- SDATA_o  out  1  serial data
- LRCLK_o  out  1  word clock
- FRAME_START_o  out  1  one-cycle pulse when a frame is loaded
- UNDERRUN_o  out  1  one-cycle pulse: no new sample at the frame boundary
- OVERRUN_o  out  1  one-cycle pulse: a buffered sample was overwritten

## Operation
- Frame length: F = 2·SLOT_W·MCLK_PER_SCLK MCLK cycles (512 with defaults). Counter cnt runs 0..F-1 and wraps.
- Input buffer: PDATA_VALID_i stores L/R and sets buf_full.
  - If buf_full is already set, the new sample overwrites the old one and OVERRUN_o pulses.
  - At a frame load with buf_full set: shift registers load from the buffer and buf_full clears.
  - At a frame load with buf_full clear: the previous sample is repeated and UNDERRUN_o pulses.
  - Capture and load in the same cycle: the load takes the old buffer, buf_full stays set, and there is no overrun.
- FORMAT_i and MUTE_i are sampled only at a frame load. Mid-frame changes are ignored.
- Slot bit content, driven MSB first:
  - I2S and left-justified: data followed by SLOT_W-DATA_W zeros.
  - Right-justified: SLOT_W-DATA_W sign-extension bits followed by data.
  - Mute: all zeros.
- LRCLK level: left slot is LRCLK = 1 for left-justified and right-justified; LRCLK = 0 for I2S.
- I2S data is delayed by one SCLK relative to LRCLK. The last right bit is shifted out in the first SCLK of the next frame.
- FSM:
  - IDLE: EN_i=1 and buf_full → LOAD.
  - LOAD: one cycle. Loads shift registers, sets cnt=0, pulses FRAME_START_o → RUN.
  - RUN: at cnt=F-1 performs a frame load and pulses FRAME_START_o.
  - EN_i=0 in any state → IDLE on the next cycle, with buf_full, the I2S delay bit and cnt cleared.
- IDLE outputs: SCLK_o=1, SDATA_o=0, LRCLK_o=0. No pulses are generated.
- Reset values: all outputs 0 except SCLK_o=1; FSM in IDLE; buf_full=0; buffer, shift registers and counter all 0.

## Timing
- Let H = MCLK_PER_SCLK/2.
- SCLK_o falls on cycles with cnt mod MCLK_PER_SCLK = 0 and rises on cnt mod MCLK_PER_SCLK = H.
- SDATA_o changes only on SCLK falling edges and is stable at each rising edge.
- LRCLK_o toggles together with the SCLK falling edge at cnt=0 (left slot) and cnt=SLOT_W·MCLK_PER_SCLK (right slot).
- All outputs are registered. A cnt value produces its output one MCLK later.
- The first falling edge after LOAD is bit 0 of the left slot. For I2S, that edge carries the delay bit, which is 0 after IDLE.
- Latency: a sample captured in frame n is transmitted in frame n+1.
- Frame loads happen every F cycles without jitter, including underrun frames.

## Structure
- Package i2s_tx_pkg holds:
  - FORMAT_I2S/LJ/RJ encodings
  - FSM state encodings
  - idle output levels
  - function clog2 for counter width
- Sub-module i2s_tx_clkgen: cnt, SCLK_o/LRCLK_o generation, and the fall_en/load_en strobes. The top level keeps the buffer, shift registers and FSM.

## Test plan
- Defaults, left-justified, L=24'h800001, R=24'h7FFFFF: left slot = 800001 then 00, right slot = 7FFFFF then 00; LRCLK high during left; period 512 MCLK.
- I2S, L=24'hA5A5A5: SDATA at the second rising SCLK edge after the LRCLK falling edge = 1 (MSB); LRCLK low for left; last right LSB appears in the first SCLK of the next frame.
- Right-justified, DATA_W=16, SLOT_W=32, L=16'h8000: left slot = 16 ones then 8000.
- Valid strobe every 2 frames: UNDERRUN_o pulses once per 2 frames and the repeated sample matches exactly; two strobes within one frame → OVERRUN_o pulses once and the second sample is transmitted.
- MUTE_i raised mid-frame: current frame unchanged; next frame all zeros; FORMAT_i change mid-frame takes effect only at the next FRAME_START_o.
- EN_i dropped mid-slot → the next cycle gives SCLK=1, SDATA=0, LRCLK=0. Re-enable plus a valid strobe → LOAD, first falling edge at cnt=0. nRST_i asserted mid-frame → reset values immediately.
